// File: rtl/core_pkg.sv
// Shared types and constants for the instruction-memory loader.
package core_pkg;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_DATA,
        ST_FLUSH,
        ST_RUN,
        ST_ERR
    } loader_state_e;

    localparam int HDR_BYTES  = 4;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Host byte channel plus ROM write port, start and status lines of the loader.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  io_in_valid;
    logic                  io_in_ready;
    logic [7:0]            io_in_data;
    logic                  io_out_mem_wen;
    logic [ADDR_WIDTH-1:0] io_out_mem_addr;
    logic [31:0]           io_out_mem_wdata;
    logic                  io_out_start;
    logic                  io_out_done;
    logic                  io_out_error;
    logic [ADDR_WIDTH:0]   io_out_loaded_words;

    // master is the loader itself; slave is the host/core environment.
    modport master (
        input  io_in_valid, io_in_data,
        output io_in_ready, io_out_mem_wen, io_out_mem_addr, io_out_mem_wdata,
               io_out_start, io_out_done, io_out_error, io_out_loaded_words
    );

    modport slave (
        output io_in_valid, io_in_data,
        input  io_in_ready, io_out_mem_wen, io_out_mem_addr, io_out_mem_wdata,
               io_out_start, io_out_done, io_out_error, io_out_loaded_words
    );
endinterface

// File: rtl/byte_word_packer.sv
// Little-endian 8->32 assembler: first byte lands in bits 7:0, word_valid pulses with the last byte.
module byte_word_packer
    import core_pkg::*;
(
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    take,
    input  logic [7:0]              data,
    output logic                    word_valid,
    output logic [8*WORD_BYTES-1:0] word
);

    localparam int IDX_W   = $clog2(WORD_BYTES);
    localparam int SHIFT_W = 8 * (WORD_BYTES - 1);

    logic [IDX_W-1:0]   idx_reg;
    logic [SHIFT_W-1:0] shift_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            idx_reg   <= '0;
            shift_reg <= '0;
        end else if (take) begin
            idx_reg   <= idx_reg + IDX_W'(1);
            shift_reg <= {data, shift_reg[SHIFT_W-1:8]};
        end
    end

    // The final byte bypasses the register so the word is usable in its accept cycle.
    assign word       = {data, shift_reg};
    assign word_valid = take && (idx_reg == IDX_W'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program image into the instruction ROM, then releases the core via start.
module imem_loader
    import core_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int BASE_ADDR  = 0
) (
    input  logic          clock,
    input  logic          reset,
    imem_loader_if.master bus
);

    localparam logic [31:0]           CAPACITY = 32'((64'd1 << ADDR_WIDTH) - 64'(BASE_ADDR));
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

    loader_state_e         state_reg, state_next;
    logic                  ready_reg, ready_next;
    logic                  last_reg, last_next;
    logic                  wen_reg;
    logic [31:0]           wdata_reg;
    logic [31:0]           count_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [ADDR_WIDTH:0]   loaded_reg;

    logic        take;
    logic        pk_valid;
    logic [31:0] pk_word;
    logic        hdr_done;
    logic        data_done;
    logic        is_last;

    assign take      = bus.io_in_valid && ready_reg;
    assign hdr_done  = pk_valid && (state_reg == ST_HDR);
    assign data_done = pk_valid && (state_reg == ST_DATA);
    // Earlier words have already been counted by the time the next one completes.
    assign is_last   = (32'(loaded_reg) + 32'd1) == count_reg;

    byte_word_packer u_packer (
        .clk        (clock),
        .srst       (reset),
        .take       (take),
        .data       (bus.io_in_data),
        .word_valid (pk_valid),
        .word       (pk_word)
    );

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        unique case (state_reg)
            ST_HDR: begin
                if (hdr_done) begin
                    if (pk_word == 32'd0)          state_next = ST_FLUSH;
                    else if (pk_word > CAPACITY)   state_next = ST_ERR;
                    else                           state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (data_done && is_last) last_next = 1'b1;
                // Leave only once the final write strobe is on the bus.
                if (wen_reg && last_reg)  state_next = ST_FLUSH;
            end
            ST_FLUSH: state_next = ST_RUN;
            ST_RUN:   state_next = ST_RUN;
            ST_ERR:   state_next = ST_ERR;
            default:  state_next = ST_HDR;
        endcase
        ready_next = (state_next == ST_HDR) || ((state_next == ST_DATA) && !last_next);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= ST_HDR;
            ready_reg  <= 1'b0;
            last_reg   <= 1'b0;
            wen_reg    <= 1'b0;
            wdata_reg  <= '0;
            count_reg  <= '0;
            addr_reg   <= BASE;
            loaded_reg <= '0;
        end else begin
            state_reg <= state_next;
            ready_reg <= ready_next;
            last_reg  <= last_next;
            wen_reg   <= data_done;
            if (data_done) wdata_reg <= pk_word;
            if (hdr_done)  count_reg <= pk_word;
            if (wen_reg) begin
                addr_reg   <= addr_reg + ADDR_WIDTH'(1);
                loaded_reg <= loaded_reg + (ADDR_WIDTH + 1)'(1);
            end
        end
    end

    assign bus.io_in_ready         = ready_reg;
    assign bus.io_out_mem_wen      = wen_reg;
    assign bus.io_out_mem_addr     = addr_reg;
    assign bus.io_out_mem_wdata    = wdata_reg;
    assign bus.io_out_start        = (state_reg == ST_RUN);
    assign bus.io_out_done         = (state_reg == ST_RUN);
    assign bus.io_out_error        = (state_reg == ST_ERR);
    assign bus.io_out_loaded_words = loaded_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances (BASE_ADDR 0 and 16) driven through the interface.
module tb_imem_loader;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    imem_loader_if #(.ADDR_WIDTH(12)) b0 ();
    imem_loader_if #(.ADDR_WIDTH(12)) b1 ();

    imem_loader #(.ADDR_WIDTH(12), .BASE_ADDR(0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (b0.master)
    );

    imem_loader #(.ADDR_WIDTH(12), .BASE_ADDR(16)) dut16 (
        .clock (clock),
        .reset (reset),
        .bus   (b1.master)
    );

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t q0[$];
    wr_t q1[$];
    int  cyc        = 0;
    int  start0_cyc = -1;
    int  start1_cyc = -1;
    int  n_checks   = 0;
    int  n_pass     = 0;
    int  n_timeouts = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Write-strobe and start monitor, one line per ROM write.
    always @(negedge clock) begin
        if (b0.io_out_mem_wen === 1'b1) begin
            q0.push_back('{addr: b0.io_out_mem_addr, data: b0.io_out_mem_wdata, cyc: cyc});
            $display("dut   write addr=%0d data=%08h cycle=%0d", b0.io_out_mem_addr, b0.io_out_mem_wdata, cyc);
        end
        if (b1.io_out_mem_wen === 1'b1) begin
            q1.push_back('{addr: b1.io_out_mem_addr, data: b1.io_out_mem_wdata, cyc: cyc});
            $display("dut16 write addr=%0d data=%08h cycle=%0d", b1.io_out_mem_addr, b1.io_out_mem_wdata, cyc);
        end
        if (b0.io_out_start === 1'b1 && start0_cyc < 0) start0_cyc <= cyc;
        if (b1.io_out_start === 1'b1 && start1_cyc < 0) start1_cyc <= cyc;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic wr_t at(input wr_t q[$], input int i);
        wr_t none;
        none = '{addr: '1, data: '1, cyc: -99};
        return (i < q.size()) ? q[i] : none;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Offers one byte; t returns the cycle in which it was accepted.
    task automatic send_byte(input bit sel, input logic [7:0] b, output int t);
        int waited;
        t = -1;
        waited = 0;
        if (sel) begin b1.io_in_valid = 1'b1; b1.io_in_data = b; end
        else     begin b0.io_in_valid = 1'b1; b0.io_in_data = b; end
        while (t < 0 && waited < 40) begin
            if ((sel ? b1.io_in_ready : b0.io_in_ready) === 1'b1) t = cyc;
            tick(1);
            waited++;
        end
        if (sel) b1.io_in_valid = 1'b0;
        else     b0.io_in_valid = 1'b0;
        if (t < 0) n_timeouts++;
    endtask

    task automatic send_word(input bit sel, input logic [31:0] w, input int gap_max, output int t);
        for (int k = 0; k < 4; k++) begin
            send_byte(sel, w[8*k +: 8], t);
            if (gap_max > 0) tick(int'($urandom_range(0, gap_max)));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        q0.delete();
        q1.delete();
        start0_cyc = -1;
        start1_cyc = -1;
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_ready"},  b0.io_in_ready, 0);
        chk({p, "_wen"},    b0.io_out_mem_wen, 0);
        chk({p, "_addr"},   b0.io_out_mem_addr, 0);
        chk({p, "_wdata"},  b0.io_out_mem_wdata, 0);
        chk({p, "_start"},  b0.io_out_start, 0);
        chk({p, "_done"},   b0.io_out_done, 0);
        chk({p, "_error"},  b0.io_out_error, 0);
        chk({p, "_loaded"}, b0.io_out_loaded_words, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t_w0, t_w1, t_w2;
        b0.io_in_valid = 1'b0; b0.io_in_data = 8'h00;
        b1.io_in_valid = 1'b0; b1.io_in_data = 8'h00;

        // Reset state, then ready in the cycle after reset drops.
        tick(3);
        chk_reset_vals("rst");
        chk("rst_addr16", b1.io_out_mem_addr, 16);
        reset = 1'b0;
        tick(1);
        chk("ready_after_rst", b0.io_in_ready, 1);

        // Two words back-to-back.
        send_word(0, 32'd2, 0, t);
        send_word(0, 32'h0000_0013, 0, t_w0);
        send_word(0, 32'h0010_0093, 0, t_w1);
        tick(6);
        chk("b2b_count",  q0.size(), 2);
        chk("b2b_addr0",  at(q0, 0).addr, 0);
        chk("b2b_data0",  at(q0, 0).data, 32'h0000_0013);
        chk("b2b_cyc0",   at(q0, 0).cyc, t_w0 + 1);
        chk("b2b_addr1",  at(q0, 1).addr, 1);
        chk("b2b_data1",  at(q0, 1).data, 32'h0010_0093);
        chk("b2b_cyc1",   at(q0, 1).cyc, t_w1 + 1);
        chk("b2b_gap",    t_w1 - t_w0, 4);
        chk("b2b_loaded", b0.io_out_loaded_words, 2);
        chk("b2b_start",  b0.io_out_start, 1);
        chk("b2b_done",   b0.io_out_done, 1);
        chk("b2b_stcyc",  start0_cyc, t_w1 + 3);
        chk("b2b_ready",  b0.io_in_ready, 0);
        chk("b2b_error",  b0.io_out_error, 0);

        // Empty image: start two cycles after the last header byte.
        do_reset();
        send_word(0, 32'd0, 0, t);
        tick(5);
        chk("n0_nowen",  q0.size(), 0);
        chk("n0_stcyc",  start0_cyc, t + 2);
        chk("n0_done",   b0.io_out_done, 1);
        chk("n0_loaded", b0.io_out_loaded_words, 0);

        // Oversized header (4097 > 4096).
        do_reset();
        send_word(0, 32'd4097, 0, t);
        chk("err_cyc_after", b0.io_out_error, 1);
        chk("err_start",     b0.io_out_start, 0);
        chk("err_ready",     b0.io_in_ready, 0);
        b0.io_in_valid = 1'b1;
        b0.io_in_data  = 8'hAA;
        tick(8);
        b0.io_in_valid = 1'b0;
        chk("err_nowen",   q0.size(), 0);
        chk("err_sticky",  b0.io_out_error, 1);
        chk("err_start2",  b0.io_out_start, 0);
        chk("err_loaded",  b0.io_out_loaded_words, 0);

        // Exactly full capacity is accepted.
        do_reset();
        send_word(0, 32'd4096, 0, t);
        chk("cap_noerr", b0.io_out_error, 0);
        chk("cap_ready", b0.io_in_ready, 1);

        // Three words with random valid gaps.
        do_reset();
        send_word(0, 32'd3, 2, t);
        send_word(0, 32'h0000_0013, 2, t_w0);
        send_word(0, 32'h0010_0093, 2, t_w1);
        send_word(0, 32'hCAFE_F00D, 2, t_w2);
        tick(6);
        chk("gap_count", q0.size(), 3);
        chk("gap_a0", at(q0, 0).addr, 0);
        chk("gap_d0", at(q0, 0).data, 32'h0000_0013);
        chk("gap_c0", at(q0, 0).cyc, t_w0 + 1);
        chk("gap_a1", at(q0, 1).addr, 1);
        chk("gap_d1", at(q0, 1).data, 32'h0010_0093);
        chk("gap_c1", at(q0, 1).cyc, t_w1 + 1);
        chk("gap_a2", at(q0, 2).addr, 2);
        chk("gap_d2", at(q0, 2).data, 32'hCAFE_F00D);
        chk("gap_c2", at(q0, 2).cyc, t_w2 + 1);
        chk("gap_start", b0.io_out_start, 1);
        chk("gap_loaded", b0.io_out_loaded_words, 3);

        // Reset after five data bytes, then a fresh one-word image.
        do_reset();
        send_word(0, 32'd2, 0, t);
        send_word(0, 32'h0000_0013, 0, t);
        send_byte(0, 8'h93, t);
        tick(1);
        reset = 1'b1;
        tick(1);
        chk_reset_vals("mid");
        reset = 1'b0;
        q0.delete();
        start0_cyc = -1;
        send_word(0, 32'd1, 0, t);
        send_word(0, 32'h1234_5678, 0, t_w0);
        tick(5);
        chk("mid_count", q0.size(), 1);
        chk("mid_addr",  at(q0, 0).addr, 0);
        chk("mid_data",  at(q0, 0).data, 32'h1234_5678);
        chk("mid_start", b0.io_out_start, 1);
        chk("mid_stcyc", start0_cyc, t_w0 + 3);

        // Non-zero base address.
        do_reset();
        send_word(1, 32'd1, 0, t);
        send_word(1, 32'hDEAD_BEEF, 0, t_w0);
        tick(5);
        chk("base_count",  q1.size(), 1);
        chk("base_addr",   at(q1, 0).addr, 16);
        chk("base_data",   at(q1, 0).data, 32'hDEAD_BEEF);
        chk("base_loaded", b1.io_out_loaded_words, 1);
        chk("base_start",  b1.io_out_start, 1);
        chk("base_stcyc",  start1_cyc, t_w0 + 3);

        chk("no_timeouts", n_timeouts, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
